cellrv32_pwm_dtg: RTL and testbench
===================================

CELLRV32_PWM_DTG -- requirements
Module: cellrv32_pwm_dtg

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 0, number of active channels (0..12); channels >= NUM_CHANNELS drive both outputs 0.
REQ-002 SHALL have parameter DTG_BASE, default 32'hFFFFFF70, 8-byte-aligned word base address of the register window.
REQ-003 SHALL have port clk_i  input  1  global clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port addr_i  input  32  bus address.
REQ-006 SHALL have port rden_i  input  1  read enable.
REQ-007 SHALL have port wren_i  input  1  write enable.
REQ-008 SHALL have port data_i  input  32  write data.
REQ-009 SHALL have port data_o  output  32  read data.
REQ-010 SHALL have port ack_o  output  1  transfer acknowledge.
REQ-011 SHALL have port pwm_i  input  12  raw PWM from cellrv32_pwm pwm_o.
REQ-012 SHALL have port fault_i  input  1  external fault, active-high.
REQ-013 SHALL have port pwm_h_o  output  12  high-side gate drive.
REQ-014 SHALL have port pwm_l_o  output  12  low-side gate drive.

Function
REQ-015 SHALL decode access when addr_i[31:3] == DTG_BASE[31:3]; offset 0 = CTRL, offset 4 = STATUS (read-only; writes ignored).
REQ-016 CTRL SHALL hold bit0 enable (r/w), bits 15:8 dead time DT (r/w); bit1 write-1 = fault clear, reads 0; other bits read 0.
REQ-017 STATUS bit31 SHALL read the fault flag; other bits 0.
REQ-018 ack_o SHALL assert exactly one cycle after any decoded rden_i or wren_i; data_o SHALL be 0 in every cycle not following a decoded read.
REQ-019 pwm_i SHALL be registered once (pwm_q) before use.
REQ-020 Each active channel SHALL run a one-hot FSM LOW, DEAD_R, HIGH, DEAD_F plus an 8-bit down-counter; outputs decoded from state only: pwm_h_o = HIGH, pwm_l_o = LOW.
REQ-021 LOW: pwm_q=1 and DT=0 -> HIGH; pwm_q=1 and DT>0 -> DEAD_R, counter loaded DT-1.
REQ-022 DEAD_R: pwm_q=0 -> LOW (pulse swallowed); else counter=0 -> HIGH; else decrement.
REQ-023 HIGH: pwm_q=0 and DT=0 -> LOW; pwm_q=0 and DT>0 -> DEAD_F, counter loaded DT-1.
REQ-024 DEAD_F: counter=0 -> LOW regardless of pwm_q; else decrement.
REQ-025 Latency: pwm_l_o falls 2 cycles after pwm_i rises; pwm_h_o rises DT+2 cycles after; symmetric on falling edge; pwm_h_o and pwm_l_o SHALL never both be 1.
REQ-026 DT write during DEAD_R/DEAD_F SHALL NOT affect the running counter; new DT applies at next load.
REQ-027 enable=0 SHALL force every FSM to LOW and drive both outputs 0 from the next cycle; re-enable resumes from LOW.

Reset
REQ-028 rst_i SHALL clear enable, DT, fault flag, pwm_q, counters, ack_o, data_o and set every FSM to LOW; pwm_h_o = pwm_l_o = 0 during and after reset until enabled.
REQ-029 rst_i mid dead-time SHALL abort the interval with no output pulse.

Configuration
REQ-030 Macro CELLRV32_PWM_DTG_FAULT_EN defined: fault_i registered; registered high sets fault flag; flag forces all FSMs to LOW and both outputs 0, as for enable=0; fault clear while registered fault_i=1 SHALL leave flag set (set wins).
REQ-031 Macro CELLRV32_PWM_DTG_FAULT_EN undefined: fault_i ignored, fault flag constant 0, STATUS bit31 reads 0, fault clear has no effect.

Verification
REQ-032 NUM_CHANNELS=2, CTRL=0x0000_0401 (DT=4), pwm_i[0] 0->1 held 20 cycles -> pwm_l_o[0] falls at +2, pwm_h_o[0] rises at +6; falling edge mirrors; no overlap.
REQ-033 DT=4, pwm_i[1] high 3 cycles -> pwm_h_o[1] stays 0; pwm_l_o[1] returns 1 with no HIGH phase.
REQ-034 DT=0, pwm_i[0] toggles each 5 cycles -> outputs complementary, 2-cycle latency, no dead gap.
REQ-035 Running 50% PWM, write CTRL=0 -> next cycle pwm_h_o=pwm_l_o=0; read CTRL -> 0x0; ack_o one cycle after each access.
REQ-036 With CELLRV32_PWM_DTG_FAULT_EN: fault_i pulse -> outputs 0, STATUS=0x8000_0000; clear while fault_i=1 -> flag stays; clear after fault_i=0 -> STATUS=0, channels resume from LOW.

Source files
------------

// File: rtl/cellrv32_pwm_dtg.sv
// ----------------------------------------------------------------------------
// cellrv32_pwm_dtg -- dead-time generator for the cellrv32 PWM unit.
//
// Turns each raw PWM line into a complementary high-side / low-side gate-drive
// pair. A programmable dead time is inserted between one switch turning off
// and the other turning on, so both sides are never driven together.
//
// Optional feature: define CELLRV32_PWM_DTG_FAULT_EN to enable the external
// fault input. A registered fault latches a sticky flag that forces every
// channel off until software clears it. When the macro is undefined, fault_i
// is ignored and the flag always reads 0.
//
// Register window (word aligned, 8 bytes at DTG_BASE):
//   +0 CTRL   : [0] enable, [1] fault clear (write-1, reads 0), [15:8] DT
//   +4 STATUS : [31] fault flag (read-only)
//
// Ports:
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   addr_i/rden_i/wren_i/data_i  bus request
//   data_o/ack_o     bus response, one cycle after a decoded access
//   pwm_i[11:0]      raw PWM from cellrv32_pwm
//   fault_i          external fault, active-high
//   pwm_h_o/pwm_l_o  high-side / low-side gate drive per channel
// ----------------------------------------------------------------------------
module cellrv32_pwm_dtg #(
    parameter int          NUM_CHANNELS = 0,
    parameter logic [31:0] DTG_BASE     = 32'hFFFFFF70
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic [11:0] pwm_i,
    input  logic        fault_i,
    output logic [11:0] pwm_h_o,
    output logic [11:0] pwm_l_o
);

    localparam int MAX_CH = 12;

    logic        acc_en;
    logic        ctrl_wr;
    logic        enable;
    logic [7:0]  dt;
    logic        fault_flag;
    logic [11:0] pwm_q;
    logic        run;

    assign acc_en  = (addr_i[31:3] == DTG_BASE[31:3]);
    assign ctrl_wr = acc_en & wren_i & ~addr_i[2];
    assign run     = enable & ~fault_flag;

    // Bus interface, control register and PWM input register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable <= 1'b0;
            dt     <= '0;
            pwm_q  <= '0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o  <= acc_en & (rden_i | wren_i);
            data_o <= '0;
            if (acc_en & rden_i) begin
                if (addr_i[2]) data_o <= {fault_flag, 31'b0};
                else           data_o <= {16'b0, dt, 6'b0, 1'b0, enable};
            end
            if (ctrl_wr) begin
                enable <= data_i[0];
                dt     <= data_i[15:8];
            end
            pwm_q <= pwm_i;
        end
    end

`ifdef CELLRV32_PWM_DTG_FAULT_EN
    logic fault_q;

    // A registered fault takes priority over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q    <= 1'b0;
            fault_flag <= 1'b0;
        end else begin
            fault_q <= fault_i;
            if (fault_q)                    fault_flag <= 1'b1;
            else if (ctrl_wr && data_i[1])  fault_flag <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_i[31:16], data_i[7:2], addr_i[1:0], pwm_q, run};
`else
    assign fault_flag = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{fault_i, data_i[31:16], data_i[7:1], addr_i[1:0], pwm_q, run};
`endif

    // Channels above NUM_CHANNELS are tied off.
    for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
        if (g < NUM_CHANNELS) begin : g_act
            cellrv32_pwm_dtg_lane u_lane (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .run_i (run),
                .pwm_i (pwm_q[g]),
                .dt_i  (dt),
                .h_o   (pwm_h_o[g]),
                .l_o   (pwm_l_o[g])
            );
        end else begin : g_off
            assign pwm_h_o[g] = 1'b0;
            assign pwm_l_o[g] = 1'b0;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// cellrv32_pwm_dtg_lane -- one dead-time channel.
//
// One-hot FSM LOW -> DEAD_R -> HIGH -> DEAD_F with an 8-bit down-counter.
// The counter is loaded with DT-1 only on entry to a dead interval, so a DT
// change mid-interval takes effect at the next load.
//
// Ports:
//   clk_i, rst_i  clock / synchronous reset
//   run_i         enable and no fault; low forces LOW and gates both outputs
//   pwm_i         registered raw PWM for this channel
//   dt_i          dead time in cycles
//   h_o, l_o      high-side / low-side drive
// ----------------------------------------------------------------------------
module cellrv32_pwm_dtg_lane (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       pwm_i,
    input  logic [7:0] dt_i,
    output logic       h_o,
    output logic       l_o
);

    localparam logic [3:0] S_LOW    = 4'b0001;
    localparam logic [3:0] S_DEAD_R = 4'b0010;
    localparam logic [3:0] S_HIGH   = 4'b0100;
    localparam logic [3:0] S_DEAD_F = 4'b1000;

    logic [3:0] state;
    logic [7:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            state <= S_LOW;
            cnt   <= '0;
        end else begin
            case (state)
                S_LOW: begin
                    if (pwm_i) begin
                        if (dt_i == 8'd0) begin
                            state <= S_HIGH;
                        end else begin
                            state <= S_DEAD_R;
                            cnt   <= dt_i - 8'd1;
                        end
                    end
                end
                S_DEAD_R: begin
                    // A PWM pulse shorter than the dead time is swallowed.
                    if (!pwm_i)            state <= S_LOW;
                    else if (cnt == 8'd0)  state <= S_HIGH;
                    else                   cnt   <= cnt - 8'd1;
                end
                S_HIGH: begin
                    if (!pwm_i) begin
                        if (dt_i == 8'd0) begin
                            state <= S_LOW;
                        end else begin
                            state <= S_DEAD_F;
                            cnt   <= dt_i - 8'd1;
                        end
                    end
                end
                S_DEAD_F: begin
                    if (cnt == 8'd0) state <= S_LOW;
                    else             cnt   <= cnt - 8'd1;
                end
                default: state <= S_LOW;
            endcase
        end
    end

    // run_i is registered, so gating here keeps the outputs glitch-free and
    // turns them off in the very next cycle after a disable or fault.
    assign h_o = state[2] & run_i;
    assign l_o = state[0] & run_i;

endmodule

// File: tb/tb_cellrv32_pwm_dtg.sv
module tb_cellrv32_pwm_dtg;

    localparam logic [31:0] BASE   = 32'hFFFFFF70;
    localparam logic [31:0] CTRL_A = BASE;
    localparam logic [31:0] STAT_A = BASE + 32'd4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic        rden_i;
    logic        wren_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic [11:0] pwm_i;
    logic        fault_i;
    logic [11:0] pwm_h_o;
    logic [11:0] pwm_l_o;

    int n_tests = 0;
    int n_fail  = 0;

    cellrv32_pwm_dtg #(.NUM_CHANNELS(2), .DTG_BASE(BASE)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .rden_i  (rden_i),
        .wren_i  (wren_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .ack_o   (ack_o),
        .pwm_i   (pwm_i),
        .fault_i (fault_i),
        .pwm_h_o (pwm_h_o),
        .pwm_l_o (pwm_l_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [11:0] exp_h, input logic [11:0] exp_l);
        chk({tag, "_h"}, {20'b0, pwm_h_o}, {20'b0, exp_h});
        chk({tag, "_l"}, {20'b0, pwm_l_o}, {20'b0, exp_l});
        chk({tag, "_ovl"}, {20'b0, pwm_h_o & pwm_l_o}, 32'd0);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr_i = a; data_i = d; wren_i = 1'b1;
        tick;
        wren_i = 1'b0;
        chk("wr_ack", {31'b0, ack_o}, 32'd1);
        tick;
        chk("wr_ack_clr", {31'b0, ack_o}, 32'd0);
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr_i = a; rden_i = 1'b1;
        tick;
        rden_i = 1'b0;
        chk(tag, data_o, exp);
        chk({tag, "_ack"}, {31'b0, ack_o}, 32'd1);
        tick;
        chk({tag, "_dclr"}, data_o, 32'd0);
    endtask

    logic        prev, cur;
    logic [11:0] eh, el;

    initial begin
        rst_i = 1'b1; addr_i = '0; rden_i = 1'b0; wren_i = 1'b0; data_i = '0;
        pwm_i = '0; fault_i = 1'b0;
        tick; tick;
        chk_out("rst", 12'h000, 12'h000);
        chk("rst_ack", {31'b0, ack_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        rst_i = 1'b0;
        tick;
        chk_out("post_rst", 12'h000, 12'h000);
        bus_rd(CTRL_A, 32'h0, "ctrl_rst");
        bus_rd(STAT_A, 32'h0, "stat_rst");

        // Access outside the window is not acknowledged.
        addr_i = BASE + 32'd8; rden_i = 1'b1;
        tick;
        rden_i = 1'b0;
        chk("unmapped_ack", {31'b0, ack_o}, 32'd0);
        chk("unmapped_data", data_o, 32'd0);

        // Enable with DT=4; both active channels idle low-side on.
        bus_wr(CTRL_A, 32'h0000_0401);
        chk_out("en", 12'h000, 12'h003);
        bus_wr(STAT_A, 32'hFFFF_FFFF);
        bus_rd(CTRL_A, 32'h0000_0401, "ctrl_rb");

        // Rising edge on channel 0: l falls at +2, h rises at +6.
        pwm_i[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            eh = (k >= 6) ? 12'h001 : 12'h000;
            el = (k < 2)  ? 12'h003 : 12'h002;
            chk_out("rise", eh, el);
        end
        repeat (12) tick;
        pwm_i[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            eh = (k < 2)  ? 12'h001 : 12'h000;
            el = (k >= 6) ? 12'h003 : 12'h002;
            chk_out("fall", eh, el);
        end

        // Short pulse on channel 1 is swallowed.
        pwm_i[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            el = (k >= 2 && k <= 4) ? 12'h001 : 12'h003;
            chk_out("swallow", 12'h000, el);
            if (k == 3) pwm_i[1] = 1'b0;
        end

        // DT=0: complementary outputs, 2-cycle latency.
        bus_wr(CTRL_A, 32'h0000_0001);
        prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cur = ((k / 5) % 2) == 1;
            pwm_i[0] = cur;
            tick;
            chk_out("dt0", {11'b0, prev}, {10'b0, 1'b1, ~prev});
            prev = cur;
        end

        // Disable while channel 0 is high.
        addr_i = CTRL_A; data_i = 32'h0; wren_i = 1'b1;
        tick;
        wren_i = 1'b0;
        chk("dis_ack", {31'b0, ack_o}, 32'd1);
        chk_out("dis_next", 12'h000, 12'h000);
        tick;
        chk("dis_ack_clr", {31'b0, ack_o}, 32'd0);
        bus_rd(CTRL_A, 32'h0, "ctrl_dis");
        tick;
        chk_out("dis_hold", 12'h000, 12'h000);

        // Re-enable with DT=4 and pwm held high: resumes from LOW.
        addr_i = CTRL_A; data_i = 32'h0000_0401; wren_i = 1'b1;
        tick;
        wren_i = 1'b0;
        chk("reen_ack", {31'b0, ack_o}, 32'd1);
        chk_out("reen", 12'h000, 12'h003);
        tick;
        chk_out("reen_1", 12'h000, 12'h002);
        repeat (3) tick;
        chk_out("reen_4", 12'h000, 12'h002);
        tick;
        chk_out("reen_5", 12'h001, 12'h002);

        // DT rewrite during DEAD_F leaves the running interval alone.
        pwm_i[0] = 1'b0;
        tick; tick;
        chk_out("deadf", 12'h000, 12'h002);
        bus_wr(CTRL_A, 32'h0000_0101);
        tick;
        chk_out("dtchg_hold", 12'h000, 12'h002);
        tick;
        chk_out("dtchg_low", 12'h000, 12'h003);

`ifdef CELLRV32_PWM_DTG_FAULT_EN
        fault_i = 1'b1;
        tick;
        fault_i = 1'b0;
        tick;
        chk_out("flt", 12'h000, 12'h000);
        bus_rd(STAT_A, 32'h8000_0000, "stat_flt");
        fault_i = 1'b1;
        tick; tick;
        bus_wr(CTRL_A, 32'h0000_0103);
        bus_rd(STAT_A, 32'h8000_0000, "stat_setwins");
        chk_out("flt_hold", 12'h000, 12'h000);
        fault_i = 1'b0;
        tick; tick;
        bus_wr(CTRL_A, 32'h0000_0103);
        chk_out("flt_clr", 12'h000, 12'h003);
        bus_rd(STAT_A, 32'h0, "stat_clr");
`else
        fault_i = 1'b1;
        tick; tick;
        fault_i = 1'b0;
        tick;
        chk_out("flt_ign", 12'h000, 12'h003);
        bus_rd(STAT_A, 32'h0, "stat_nofault");
        bus_wr(CTRL_A, 32'h0000_0103);
`endif
        bus_rd(CTRL_A, 32'h0000_0101, "ctrl_clrbit");

        // Reset in the middle of a dead interval: no high pulse afterwards.
        pwm_i[0] = 1'b1;
        tick; tick;
        chk_out("rdead", 12'h000, 12'h002);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        chk_out("rst_dead", 12'h000, 12'h000);
        tick; tick;
        chk_out("rst_after", 12'h000, 12'h000);
        bus_rd(CTRL_A, 32'h0, "ctrl_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
